round_countdown_timer: RTL

Consumes the 100 ms tick produced by the 1 ms-to-100 ms counting stage and runs the per-question countdown for the mental-math game. It holds a 3-digit BCD time remaining (tens of seconds, seconds, tenths), supports start, pause and abort, and issues a single-cycle expiry pulse to the game controller. It also raises a warning flag in the final seconds. The BCD digits drive the seven-segment display path directly.

---
 rtl/round_countdown_timer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/round_countdown_timer.sv
// -----------------------------------------------------------------------------
// round_countdown_timer
//
// Per-question countdown for the mental-math game. Counts a 3-digit BCD time
// (tens of seconds, seconds, tenths) down by one tenth on every 100 ms tick.
// Supports start, pause and abort. Gives the game controller a one-cycle
// expiry pulse and a warning flag for the final seconds. The digits feed the
// seven-segment display path directly.
//
// Ports
//   clk             system clock
//   rst             asynchronous active-low reset
//   Time_out_100ms  one-clk-wide 100 ms tick from the upstream counter
//   start           level: load load_bcd and begin counting (IDLE/EXPIRED only)
//   load_bcd        initial time, BCD {tens, secs, tenths}; nibbles >9 clamp to 9
//   pause           level: freezes the countdown while high
//   abort           level: return to IDLE and clear the count
//   digit_tens      remaining time, tens-of-seconds digit
//   digit_secs      remaining time, seconds digit
//   digit_tenths    remaining time, tenths digit
//   running         high in RUN
//   expired         one-clk pulse on the edge that enters EXPIRED
//   warn            high in RUN/PAUSED while 0 < remaining <= WARN_BCD
// -----------------------------------------------------------------------------
module round_countdown_timer #(
  parameter logic [11:0] WARN_BCD = 12'h050
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Time_out_100ms,
  input  logic        start,
  input  logic [11:0] load_bcd,
  input  logic        pause,
  input  logic        abort,
  output logic [3:0]  digit_tens,
  output logic [3:0]  digit_secs,
  output logic [3:0]  digit_tenths,
  output logic        running,
  output logic        expired,
  output logic        warn
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] count, count_nxt;
  logic        expired_nxt;
  logic [11:0] load_clamped;

  // Clamp one BCD nibble to the legal range 0..9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Subtract one tenth from a valid, non-zero BCD count with digit borrows.
  function automatic logic [11:0] bcd_dec(input logic [11:0] c);
    logic [3:0] t, s, u;
    t = c[11:8];
    s = c[7:4];
    u = c[3:0];
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (s != 4'd0) begin
        s = s - 4'd1;
      end else begin
        s = 4'd9;
        t = t - 4'd1;
      end
    end
    return {t, s, u};
  endfunction

  // Valid BCD digits order the same way as binary, so a plain 12-bit
  // compare is a correct BCD magnitude compare.
  function automatic logic warn_of(input state_t st, input logic [11:0] c);
    return ((st == RUN) || (st == PAUSED)) && (c != 12'h000) && (c <= WARN_BCD);
  endfunction

  assign load_clamped = {clamp_digit(load_bcd[11:8]),
                         clamp_digit(load_bcd[7:4]),
                         clamp_digit(load_bcd[3:0])};

  // Next-state logic. Priority everywhere: abort > start > pause > tick.
  // NOTE: every variable assigned here gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    expired_nxt = 1'b0;

    if (abort) begin
      state_nxt = IDLE;
      count_nxt = 12'h000;
    end else begin
      unique case (state)
        IDLE, EXPIRED: begin
          if (start) begin
            count_nxt = load_clamped;
            if (load_clamped == 12'h000) begin
              state_nxt   = EXPIRED;
              expired_nxt = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          // start is ignored here: no restart while running.
          if (pause) begin
            state_nxt = PAUSED;          // tick on this cycle is dropped
          end else if (Time_out_100ms) begin
            count_nxt = bcd_dec(count);
            if (count == 12'h001) begin
              state_nxt   = EXPIRED;
              expired_nxt = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_nxt = RUN;             // tick on the resume cycle is dropped
          end
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = 12'h000;
        end
      endcase
    end
  end

  // All outputs are flops; running/warn are decoded from the next state and
  // count so they line up with the registered digits.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= 12'h000;
      expired <= 1'b0;
      running <= 1'b0;
      warn    <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      expired <= expired_nxt;
      running <= (state_nxt == RUN);
      warn    <= warn_of(state_nxt, count_nxt);
    end
  end

  assign digit_tens   = count[11:8];
  assign digit_secs   = count[7:4];
  assign digit_tenths = count[3:0];

endmodule
